// File: rtl/cube_scan_if.sv
// Frame-in / cube-pins bundle between the frame buffer, the scan sequencer and the driver pins.
interface cube_scan_if;
  logic         en;
  logic         sync;
  logic [511:0] frame_cube_flat;
  logic         ser;
  logic         srclk;
  logic         rclk;
  logic [7:0]   layer_sel;
  logic [2:0]   scan_layer;
  logic         busy;
  logic         frame_done;

  // Frame source / enable side
  modport master (
    output en, sync, frame_cube_flat,
    input  ser, srclk, rclk, layer_sel, scan_layer, busy, frame_done
  );

  // Scan sequencer side
  modport slave (
    input  en, sync, frame_cube_flat,
    output ser, srclk, rclk, layer_sel, scan_layer, busy, frame_done
  );
endinterface

// File: rtl/cube_scan_ctrl.sv
// Scan sequencer for an 8x8x8 LED cube: double-buffered frame, per-layer serial shift,
// blank, latch and hold. Frames swap only at a layer-0 load so the display never tears.
module cube_scan_ctrl #(
  parameter int unsigned SHIFT_DIV    = 4,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  cube_scan_if.slave bus
);

  localparam int unsigned DivW   = (SHIFT_DIV > 1)    ? $clog2(SHIFT_DIV)    : 1;
  localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned HoldW  = (HOLD_CYCLES > 1)  ? $clog2(HOLD_CYCLES)  : 1;

  localparam logic [DivW-1:0]   DivLast   = DivW'(SHIFT_DIV - 1);
  localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_CYCLES - 1);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StShift, StBlank, StLatch, StHold
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          layer_q, layer_d;
  logic [511:0]        active_q, active_d;
  logic [511:0]        next_q, next_d;
  logic                pending_q, pending_d;
  logic [63:0]         shreg_q, shreg_d;
  logic [5:0]          bit_q, bit_d;
  logic [DivW-1:0]     div_q, div_d;
  logic                phase_q, phase_d;
  logic [BlankW-1:0]   blank_q, blank_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [7:0]          lsel_q, lsel_d;

  logic ser, srclk, rclk, busy, frame_done;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      layer_q   <= '0;
      active_q  <= '0;
      next_q    <= '0;
      pending_q <= 1'b0;
      shreg_q   <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      phase_q   <= 1'b0;
      blank_q   <= '0;
      hold_q    <= '0;
      lsel_q    <= '0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      active_q  <= active_d;
      next_q    <= next_d;
      pending_q <= pending_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      blank_q   <= blank_d;
      hold_q    <= hold_d;
      lsel_q    <= lsel_d;
    end
  end

  // Next-state: frame capture, buffer swap, shift timing and layer sequencing
  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    active_d  = active_q;
    next_d    = next_q;
    pending_d = pending_q;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    div_d     = div_q;
    phase_d   = phase_q;
    blank_d   = blank_q;
    hold_d    = hold_q;
    lsel_d    = lsel_q;

    // Capture runs in every state; the latest sync always wins
    if (bus.sync) begin
      next_d    = bus.frame_cube_flat;
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          state_d = StLoad;
          layer_d = '0;
        end
      end
      StLoad: begin
        // A sync landing on the layer-0 load is consumed directly, so nothing stays pending
        if (layer_q == 3'd0 && bus.sync) begin
          active_d  = bus.frame_cube_flat;
          pending_d = 1'b0;
        end else if (layer_q == 3'd0 && pending_q) begin
          active_d  = next_q;
          pending_d = 1'b0;
        end
        shreg_d = active_d[{layer_q, 6'd0} +: 64];
        bit_d   = '0;
        div_d   = '0;
        phase_d = 1'b0;
        state_d = StShift;
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            shreg_d = {shreg_q[62:0], 1'b0};
            bit_d   = bit_q + 6'd1;
            if (bit_q == 6'd63) begin
              state_d = StBlank;
              blank_d = '0;
              lsel_d  = '0;
            end
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StBlank: begin
        if (blank_q == BlankLast) state_d = StLatch;
        else                      blank_d = blank_q + BlankW'(1);
      end
      StLatch: begin
        state_d = StHold;
        hold_d  = '0;
        lsel_d  = 8'd1 << layer_q;
      end
      StHold: begin
        // en is only looked at here, so a started layer always completes
        if (hold_q == HoldLast) begin
          if (bus.en) begin
            state_d = StLoad;
            layer_d = layer_q + 3'd1;
          end else begin
            state_d = StIdle;
            layer_d = '0;
            lsel_d  = '0;
          end
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    ser        = 1'b0;
    srclk      = 1'b0;
    busy       = (state_q != StIdle);
    rclk       = (state_q == StLatch);
    frame_done = (state_q == StHold) && (hold_q == HoldLast) && (layer_q == 3'd7);
    if (state_q == StShift) begin
      ser   = shreg_q[63];
      srclk = phase_q;
    end
  end

  assign bus.ser        = ser;
  assign bus.srclk      = srclk;
  assign bus.rclk       = rclk;
  assign bus.layer_sel  = lsel_q;
  assign bus.scan_layer = layer_q;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_cube_scan_ctrl.sv
// Randomized bench for cube_scan_ctrl against a position-in-layer reference model.
module tb_cube_scan_ctrl;

  localparam int unsigned SD = 1;
  localparam int unsigned BL = 2;
  localparam int unsigned HD = 4;
  localparam int unsigned S  = 128 * SD;
  localparam int unsigned P  = 1 + S + BL + 1 + HD;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cube_scan_if bus ();

  cube_scan_ctrl #(
    .SHIFT_DIV   (SD),
    .BLANK_CYCLES(BL),
    .HOLD_CYCLES (HD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: where the scan is within the current layer, plus the frame buffers
  bit           m_run;
  int           m_layer;
  int           m_pos;
  logic [511:0] m_active, m_next;
  bit           m_pending;
  logic [63:0]  m_word;
  logic [7:0]   m_prev_lit;

  task automatic m_reset();
    m_run = 0; m_layer = 0; m_pos = 0; m_active = '0; m_next = '0;
    m_pending = 0; m_word = '0; m_prev_lit = '0;
  endtask

  task automatic m_step(input logic en, input logic sync, input logic [511:0] frame);
    if (!m_run) begin
      if (sync) begin m_next = frame; m_pending = 1; end
      if (en) begin m_run = 1; m_layer = 0; m_pos = 0; m_prev_lit = '0; end
    end else begin
      if (m_pos == 0) begin
        if (m_layer == 0 && sync) begin
          m_active = frame; m_next = frame; m_pending = 0;
        end else begin
          if (m_layer == 0 && m_pending) begin m_active = m_next; m_pending = 0; end
          if (sync) begin m_next = frame; m_pending = 1; end
        end
        m_word = m_active[64*m_layer +: 64];
      end else if (sync) begin
        m_next = frame; m_pending = 1;
      end
      if (m_pos == int'(P) - 1) begin
        if (en) begin
          m_prev_lit = 8'd1 << m_layer;
          m_layer = (m_layer + 1) % 8;
          m_pos = 0;
        end else begin
          m_run = 0; m_layer = 0; m_pos = 0; m_prev_lit = '0;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  // {ser, srclk, rclk, layer_sel, scan_layer, busy, frame_done}
  function automatic logic [15:0] exp_outs();
    logic s, c, r, fd;
    logic [7:0] ls;
    int k;
    s = 0; c = 0; r = 0; fd = 0; ls = '0;
    if (!m_run) return 16'h0;
    if (m_pos >= 1 && m_pos <= int'(S)) begin
      k = m_pos - 1;
      s = m_word[63 - k / int'(2 * SD)];
      c = (k % int'(2 * SD)) >= int'(SD);
    end
    r = (m_pos == int'(S + BL + 1));
    if (m_pos <= int'(S))               ls = m_prev_lit;
    else if (m_pos <= int'(S + BL + 1)) ls = '0;
    else                                ls = 8'd1 << m_layer;
    fd = (m_layer == 7) && (m_pos == int'(P) - 1);
    return {s, c, r, ls, 3'(m_layer), 1'b1, fd};
  endfunction

  function automatic logic [15:0] outs();
    return {bus.ser, bus.srclk, bus.rclk, bus.layer_sel, bus.scan_layer, bus.busy,
            bus.frame_done};
  endfunction

  // Per-cycle comparison on the falling edge, then advance the model with the inputs
  // that the next rising edge will sample
  always @(negedge clk) begin
    if (!rst) begin
      m_reset();
      check("rst_outs", 64'(outs()), 64'h0);
    end else begin
      check($sformatf("outs L%0d p%0d", m_layer, m_pos), 64'(outs()), 64'(exp_outs()));
      m_step(bus.en, bus.sync, bus.frame_cube_flat);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_frame();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[32*i +: 32] = $urandom;
    return f;
  endfunction

  task automatic run(input int n, input int sync_rate);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.sync = (sync_rate != 0) && ($urandom_range(sync_rate - 1) == 0);
      if (bus.sync) bus.frame_cube_flat = rand_frame();
    end
  endtask

  task automatic pulse_sync(input logic [511:0] f);
    bus.frame_cube_flat = f;
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
  endtask

  // Advance until the model says the cycle now starting is (layer l, position p)
  task automatic wait_at(input int l, input int p);
    int k;
    bit hit;
    k = 0;
    bus.sync = 1'b0;
    while (!(m_run && m_layer == l && m_pos == p) && k < int'(4 * 8 * P)) begin
      tick();
      k++;
    end
    hit = m_run && m_layer == l && m_pos == p;
    check($sformatf("wait_at L%0d p%0d", l, p), 64'(hit), 64'd1);
  endtask

  initial begin
    bus.en = 1'b0;
    bus.sync = 1'b0;
    bus.frame_cube_flat = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    tick();

    // Layer 0 = 0xFF, others dark; then free-run two frames
    pulse_sync(512'hFF);
    bus.en = 1'b1;
    run(2 * 8 * P, 0);

    // Occasional random frames
    run(2 * 8 * P, 150);

    // New frame while layer 3 is shifting: only visible from the next layer-0 load
    wait_at(3, 40);
    pulse_sync(rand_frame());
    run(2 * 8 * P, 0);

    // Sync on the layer-0 load cycle itself
    wait_at(0, 0);
    pulse_sync(rand_frame());
    run(8 * P, 0);

    // Pending frame overridden by a sync on the layer-0 load cycle
    wait_at(7, 10);
    pulse_sync(rand_frame());
    wait_at(0, 0);
    pulse_sync(rand_frame());
    run(8 * P, 0);

    // Drop en during layer 5 shift: layer 5 finishes, then idle
    wait_at(5, 20);
    bus.en = 1'b0;
    run(P + 20, 0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_lsel", 64'(bus.layer_sel), 64'd0);
    check("idle_layer", 64'(bus.scan_layer), 64'd0);
    bus.en = 1'b1;
    run(8 * P + 10, 0);

    // Asynchronous reset in the middle of a shift
    wait_at(2, 50);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", 64'(outs()), 64'h0);
    tick();
    tick();
    rst = 1'b1;
    run(8 * P, 0);
    pulse_sync(rand_frame());
    run(2 * 8 * P, 0);

    // Random en toggling with random syncs
    for (int i = 0; i < 4000; i++) begin
      tick();
      bus.sync = ($urandom_range(99) == 0);
      if (bus.sync) bus.frame_cube_flat = rand_frame();
      if ($urandom_range(399) == 0) bus.en = ~bus.en;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
